// File: rtl/fifo_rr_wr_arbiter.sv
// fifo_rr_wr_arbiter
//   Shares the write port of one FIFO among NUM_REQ valid/ready requesters.
//   Round-robin arbitration with at most MAX_BURST beats per grant. Back-to-back
//   grants on release (no idle bubble). FIFO full stalls the current grant.
// Ports
//   clk, rst      clock, synchronous active-high reset
//   req_valid     per-requester valid
//   req_data      packed requester data, requester i at [i*WIDTH +: WIDTH]
//   req_ready     per-requester accept (beat moves on valid & ready)
//   fifo_full     FIFO full flag
//   fifo_wr_en    FIFO write enable
//   fifo_data_in  FIFO write data
//   grant_valid   a requester holds the port
//   grant_id      index of the granted requester
module fifo_rr_wr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 4,
  localparam int ID_W     = $clog2(NUM_REQ),
  localparam int CNT_W    = $clog2(MAX_BURST) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic                     fifo_full,
  output logic                     fifo_wr_en,
  output logic [WIDTH-1:0]         fifo_data_in,
  output logic                     grant_valid,
  output logic [ID_W-1:0]          grant_id
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                          state, state_nx;
  logic [ID_W-1:0]                 grant_nx;
  logic [CNT_W-1:0]                beat_cnt, cnt_nx;
  logic [ID_W-1:0]                 rr_ptr, ptr_nx;
  logic                            pick_vld;
  logic [ID_W-1:0]                 pick_id;
  logic                            beat, rel;
  logic [NUM_REQ-1:0][WIDTH-1:0]   data_arr;

  assign data_arr    = req_data;
  assign grant_valid = (state == GRANT);

  // rst gates the strobes so an in-flight beat is dropped in the reset cycle.
  assign fifo_wr_en   = grant_valid & req_valid[grant_id] & ~fifo_full & ~rst;
  assign fifo_data_in = grant_valid ? data_arr[grant_id] : '0;
  assign beat         = fifo_wr_en;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_rdy
    assign req_ready[i] = grant_valid & (grant_id == ID_W'(i)) & ~fifo_full & ~rst;
  end

  // Round-robin pick starting after rr_ptr. In GRANT rr_ptr equals grant_id, so
  // the releasing requester lands last in the search order. Scanning from the
  // far end lets the nearest valid requester overwrite earlier hits.
  always_comb begin
    int idx;
    pick_vld = 1'b0;
    pick_id  = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (req_valid[idx]) begin
        pick_vld = 1'b1;
        pick_id  = ID_W'(idx);
      end
    end
  end

  always_comb begin
    state_nx = state;
    grant_nx = grant_id;
    cnt_nx   = beat_cnt;
    ptr_nx   = rr_ptr;
    rel      = 1'b0;
    case (state)
      IDLE: rel = 1'b1;
      GRANT: begin
        if (beat) begin
          if (beat_cnt == CNT_W'(MAX_BURST - 1)) rel = 1'b1;
          else cnt_nx = beat_cnt + CNT_W'(1);
        end else if (!req_valid[grant_id]) begin
          rel = 1'b1;
        end
        // valid & full: stall, hold everything
      end
      default: rel = 1'b1;
    endcase
    if (rel) begin
      if (pick_vld) begin
        state_nx = GRANT;
        grant_nx = pick_id;
        cnt_nx   = '0;
        ptr_nx   = pick_id;
      end else begin
        state_nx = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      grant_id <= '0;
      beat_cnt <= '0;
      rr_ptr   <= ID_W'(NUM_REQ - 1);
    end else begin
      state    <= state_nx;
      grant_id <= grant_nx;
      beat_cnt <= cnt_nx;
      rr_ptr   <= ptr_nx;
    end
  end

endmodule
